vdcm_ssm_mux: RTL and testbench



---
 rtl/vdcm_ssm_mux_pkg.sv | 23 ++
 rtl/vdcm_ssm_mux_if.sv | 27 ++
 rtl/vdcm_sync_fifo.sv | 54 +++++
 rtl/vdcm_ssm_mux.sv | 143 ++++++++++++++
 tb/tb_vdcm_ssm_mux.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/vdcm_ssm_mux_pkg.sv
// Shared types for the VDC-M substream multiplexer: substream masks and indices,
// the sequencer state type, and a lowest-set-bit selector.
package vdcm_ssm_mux_pkg;

  localparam int NUM_SSM = 4;

  typedef logic [NUM_SSM-1:0] ssm_mask_t;
  typedef logic [1:0]         ssm_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } mux_state_t;

  // Priority goes to the lowest index; this is the decoder's consume order.
  function automatic ssm_idx_t lowest_set(input ssm_mask_t m);
    lowest_set = '0;
    for (int i = NUM_SSM - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = ssm_idx_t'(i);
    end
  endfunction

endpackage

// File: rtl/vdcm_ssm_mux_if.sv
// Handshake bundle of the substream mux: four-lane group input side and single-word
// bitstream output side.
interface vdcm_ssm_mux_if
  import vdcm_ssm_mux_pkg::*;
#(
  parameter int DW = 128
);

  ssm_mask_t                   in_vld;
  logic [NUM_SSM-1:0][DW-1:0]  in_data;
  logic                        in_rdy;
  logic                        out_vld;
  logic [DW-1:0]               out_data;
  logic                        out_rdy;
  ssm_idx_t                    out_ssm;

  modport slave (
    input  in_vld, in_data, out_rdy,
    output in_rdy, out_vld, out_data, out_ssm
  );

  modport master (
    output in_vld, in_data, out_rdy,
    input  in_rdy, out_vld, out_data, out_ssm
  );

endinterface

// File: rtl/vdcm_sync_fifo.sv
// Synchronous FIFO with a flop array and combinational head; push ignored when full,
// pop ignored when empty.
module vdcm_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage is not reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vdcm_ssm_mux.sv
// Serializes per-cycle groups from four substream encoders into one word stream, lowest index
// first; first word one cycle after acceptance, stalls hold output. Option: VDCM_SSM_MUX_STATS_EN.
module vdcm_ssm_mux
  import vdcm_ssm_mux_pkg::*;
#(
  parameter int DW             = 128,
  parameter int SSM_FIFO_DEPTH = 16,
  parameter int GRP_FIFO_DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  vdcm_ssm_mux_if.slave              bus
`ifdef VDCM_SSM_MUX_STATS_EN
  ,
  output logic [NUM_SSM-1:0][31:0]   stat_words,
  output logic [31:0]                stat_groups
`endif
);

  localparam int SCW = $clog2(SSM_FIFO_DEPTH) + 1;
  localparam int GCW = $clog2(GRP_FIFO_DEPTH) + 1;

  logic [NUM_SSM-1:0][DW-1:0]  ssm_head;
  logic [NUM_SSM-1:0]          ssm_full;
  logic [NUM_SSM-1:0]          ssm_empty;
  logic [NUM_SSM-1:0]          ssm_push;
  logic [NUM_SSM-1:0]          ssm_pop;
  logic [NUM_SSM-1:0][SCW-1:0] ssm_count;

  ssm_mask_t                   grp_head;
  logic                        grp_full;
  logic                        grp_empty;
  logic                        grp_pop;
  logic [GCW-1:0]              grp_count;

  mux_state_t                  state;
  ssm_mask_t                   sent;
  ssm_mask_t                   remaining;
  ssm_mask_t                   sel_oh;
  ssm_idx_t                    sel;
  logic                        accept;
  logic                        fire;
  logic                        last_word;
  logic                        unused_status;

  // Ready looks only at registered occupancy, so a same-cycle pop never admits a group.
  assign bus.in_rdy = !rst && !(|ssm_full) && !grp_full;
  assign accept     = bus.in_rdy && (bus.in_vld != '0);

  assign remaining  = grp_head & ~sent;
  assign sel        = lowest_set(remaining);
  assign sel_oh     = ssm_mask_t'(1) << sel;
  assign last_word  = ((remaining & ~sel_oh) == '0);

  assign bus.out_vld  = (state == EMIT);
  assign bus.out_ssm  = bus.out_vld ? sel : '0;
  assign bus.out_data = bus.out_vld ? ssm_head[sel] : '0;

  assign fire    = bus.out_vld && bus.out_rdy;
  assign grp_pop = fire && last_word;

  for (genvar s = 0; s < NUM_SSM; s++) begin : g_ssm
    assign ssm_push[s] = accept && bus.in_vld[s];
    assign ssm_pop[s]  = fire && (sel == ssm_idx_t'(s)) && !ssm_empty[s];

    vdcm_sync_fifo #(
      .WIDTH (DW),
      .DEPTH (SSM_FIFO_DEPTH)
    ) u_ssm_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (ssm_push[s]),
      .push_data (bus.in_data[s]),
      .pop       (ssm_pop[s]),
      .head      (ssm_head[s]),
      .full      (ssm_full[s]),
      .empty     (ssm_empty[s]),
      .count     (ssm_count[s])
    );
  end

  vdcm_sync_fifo #(
    .WIDTH (NUM_SSM),
    .DEPTH (GRP_FIFO_DEPTH)
  ) u_grp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (bus.in_vld),
    .pop       (grp_pop),
    .head      (grp_head),
    .full      (grp_full),
    .empty     (grp_empty),
    .count     (grp_count)
  );

  assign unused_status = ^{ssm_count, grp_empty};

  // `sent` tracks words already emitted from the head group; clearing it on the last word
  // exposes the next group head in the same cycle, so consecutive groups have no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sent  <= '0;
    end else begin
      case (state)
        IDLE: begin
          sent <= '0;
          if (accept) state <= EMIT;
        end
        EMIT: begin
          if (fire) begin
            if (last_word) begin
              sent <= '0;
              if ((grp_count == GCW'(1)) && !accept) state <= IDLE;
            end else begin
              sent <= sent | sel_oh;
            end
          end
        end
        default: begin
          state <= IDLE;
          sent  <= '0;
        end
      endcase
    end
  end

`ifdef VDCM_SSM_MUX_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_words  <= '0;
      stat_groups <= '0;
    end else begin
      if (accept && (stat_groups != 32'hFFFF_FFFF)) stat_groups <= stat_groups + 1'b1;
      for (int s = 0; s < NUM_SSM; s++) begin
        if (ssm_pop[s] && (stat_words[s] != 32'hFFFF_FFFF)) stat_words[s] <= stat_words[s] + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vdcm_ssm_mux.sv
// Bench for vdcm_ssm_mux: directed vector table, full/reset sequences and random traffic
// checked against a queue-based model of the expected bitstream.
module tb_vdcm_ssm_mux;
  import vdcm_ssm_mux_pkg::*;

  localparam int DW = 128;
  localparam int SD = 16;
  localparam int GD = 16;

  typedef struct {
    logic [DW-1:0] dat;
    ssm_idx_t      ssm;
    int            gid;
  } ent_t;

  typedef struct {
    ssm_mask_t vld;
    logic      ordy;
    logic      ev;
    int        ess;
    int        eg;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vdcm_ssm_mux_if #(.DW(DW)) bus ();

`ifdef VDCM_SSM_MUX_STATS_EN
  logic [NUM_SSM-1:0][31:0] stat_words;
  logic [31:0]              stat_groups;
`endif

  vdcm_ssm_mux #(
    .DW             (DW),
    .SSM_FIFO_DEPTH (SD),
    .GRP_FIFO_DEPTH (GD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus)
`ifdef VDCM_SSM_MUX_STATS_EN
    ,
    .stat_words  (stat_words),
    .stat_groups (stat_groups)
`endif
  );

  ent_t exp_q[$];
  int   gid_next = 0;
  int   checks   = 0;
  int   errors   = 0;
  int   dut_acc  = 0;
  int   dut_out  = 0;

  function automatic logic [DW-1:0] word(input int g, input int s);
    return {32'hC0DE_0000 | 32'(g), 32'(s), 64'h5A5A_A5A5_0F0F_F0F0};
  endfunction

  // Free space as seen by the model: words still queued per substream, and groups
  // that still have at least one word outstanding.
  function automatic bit model_rdy();
    int cnt[NUM_SSM];
    int grp;
    if (rst) return 1'b0;
    for (int s = 0; s < NUM_SSM; s++) cnt[s] = 0;
    foreach (exp_q[i]) cnt[exp_q[i].ssm]++;
    grp = (exp_q.size() == 0) ? 0 : (exp_q[exp_q.size()-1].gid - exp_q[0].gid + 1);
    for (int s = 0; s < NUM_SSM; s++) if (cnt[s] >= SD) return 1'b0;
    return grp < GD;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic check_state();
    check("out_vld", DW'(bus.out_vld), DW'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("out_data", bus.out_data, exp_q[0].dat);
      check("out_ssm", DW'(bus.out_ssm), DW'(exp_q[0].ssm));
    end
    check("in_rdy", DW'(bus.in_rdy), DW'(model_rdy()));
    if (rst) begin
      check("reset out_data", bus.out_data, '0);
      check("reset out_ssm", DW'(bus.out_ssm), '0);
    end
  endtask

  task automatic cycle(input ssm_mask_t vld, input logic ordy,
                       input logic [NUM_SSM-1:0][DW-1:0] dat);
    bit   acc;
    bit   fire;
    ent_t e;
    bus.in_vld  = vld;
    bus.out_rdy = ordy;
    bus.in_data = dat;
    acc  = model_rdy() && (vld != '0);
    fire = (exp_q.size() != 0) && ordy;
    if (bus.in_rdy && (vld != '0)) dut_acc++;
    if (bus.out_vld && ordy) dut_out++;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
    end else begin
      if (fire) e = exp_q.pop_front();
      if (acc) begin
        for (int s = 0; s < NUM_SSM; s++)
          if (vld[s]) exp_q.push_back('{dat[s], ssm_idx_t'(s), gid_next});
        gid_next++;
      end
    end
    #1;
    check_state();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t                        tbl[14];
    logic [NUM_SSM-1:0][DW-1:0]  d;
    int                          base;
    int                          pr;

    tbl[0]  = '{4'hF, 1'b1, 1'b1, 0, 0};
    tbl[1]  = '{4'h0, 1'b1, 1'b1, 1, 0};
    tbl[2]  = '{4'h0, 1'b1, 1'b1, 2, 0};
    tbl[3]  = '{4'h0, 1'b1, 1'b1, 3, 0};
    tbl[4]  = '{4'h0, 1'b1, 1'b0, 0, 0};
    tbl[5]  = '{4'hA, 1'b1, 1'b1, 1, 5};
    tbl[6]  = '{4'h5, 1'b1, 1'b1, 3, 5};
    tbl[7]  = '{4'h0, 1'b1, 1'b1, 0, 6};
    tbl[8]  = '{4'h0, 1'b1, 1'b1, 2, 6};
    tbl[9]  = '{4'h0, 1'b1, 1'b0, 0, 0};
    tbl[10] = '{4'h3, 1'b0, 1'b1, 0, 10};
    tbl[11] = '{4'h0, 1'b0, 1'b1, 0, 10};
    tbl[12] = '{4'h0, 1'b1, 1'b1, 1, 10};
    tbl[13] = '{4'h0, 1'b1, 1'b0, 0, 0};

    rst = 1'b1;
    bus.in_vld  = '0;
    bus.out_rdy = 1'b0;
    bus.in_data = '0;
    repeat (2) cycle(4'h0, 1'b0, '0);
    rst = 1'b0;
    #1;
    check("in_rdy after reset", DW'(bus.in_rdy), DW'(1));

    foreach (tbl[i]) begin
      for (int s = 0; s < NUM_SSM; s++) d[s] = word(i, s);
      cycle(tbl[i].vld, tbl[i].ordy, d);
      check($sformatf("tbl%0d out_vld", i), DW'(bus.out_vld), DW'(tbl[i].ev));
      if (tbl[i].ev) begin
        check($sformatf("tbl%0d out_ssm", i), DW'(bus.out_ssm), DW'(tbl[i].ess));
        check($sformatf("tbl%0d out_data", i), bus.out_data, word(tbl[i].eg, tbl[i].ess));
      end
    end

    // Fill with a stalled output, then drain.
    base = dut_acc;
    for (int c = 0; c < 20; c++) begin
      for (int s = 0; s < NUM_SSM; s++) d[s] = word(100 + c, s);
      cycle(4'hF, 1'b0, d);
    end
    check("groups accepted while stalled", DW'(dut_acc - base), DW'((SD < GD) ? SD : GD));
    base = dut_out;
    for (int c = 0; c < 70; c++) cycle(4'h0, 1'b1, '0);
    check("words drained after release", DW'(dut_out - base), DW'(64));

    // Reset with five words pending; none of them may reappear.
    for (int s = 0; s < NUM_SSM; s++) d[s] = word(200, s);
    cycle(4'hF, 1'b0, d);
    for (int s = 0; s < NUM_SSM; s++) d[s] = word(201, s);
    cycle(4'h1, 1'b0, d);
    rst = 1'b1;
    cycle(4'h0, 1'b0, '0);
    check("out_vld after mid reset", DW'(bus.out_vld), DW'(0));
    rst = 1'b0;
    #1;
    check("in_rdy after mid reset", DW'(bus.in_rdy), DW'(1));

    // Random traffic at three output-pressure levels.
    for (int c = 0; c < 1500; c++) begin
      pr = (c < 500) ? 75 : ((c < 1000) ? 25 : 90);
      for (int s = 0; s < NUM_SSM; s++) d[s] = {$urandom, $urandom, $urandom, $urandom};
      cycle(($urandom_range(0, 3) == 0) ? 4'h0 : ssm_mask_t'($urandom_range(0, 15)),
            ($urandom_range(0, 99) < pr), d);
    end
    for (int c = 0; c < 80; c++) cycle(4'h0, 1'b1, '0);

`ifdef VDCM_SSM_MUX_STATS_EN
    rst = 1'b1;
    cycle(4'h0, 1'b0, '0);
    rst = 1'b0;
    for (int s = 0; s < NUM_SSM; s++) d[s] = word(300, s);
    cycle(4'hF, 1'b1, d);
    cycle(4'h1, 1'b1, d);
    cycle(4'h8, 1'b1, d);
    repeat (8) cycle(4'h0, 1'b1, '0);
    check("stat_groups", DW'(stat_groups), DW'(3));
    check("stat_words0", DW'(stat_words[0]), DW'(2));
    check("stat_words1", DW'(stat_words[1]), DW'(1));
    check("stat_words2", DW'(stat_words[2]), DW'(1));
    check("stat_words3", DW'(stat_words[3]), DW'(2));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
